// File: rtl/wb_pkg.sv
// Shared encodings for the write-back stage: result source and load size.
package wb_pkg;

   typedef enum logic [1:0] {
      WbAlu = 2'd0,
      WbMem = 2'd1,
      WbPc4 = 2'd2,
      WbImm = 2'd3
   } wb_sel_e;

   typedef enum logic [1:0] {
      LdByte = 2'd0,
      LdHalf = 2'd1,
      LdWord = 2'd2,
      LdRsvd = 2'd3
   } load_size_e;

   localparam int unsigned ByteW = 8;
   localparam int unsigned HalfW = 16;

endpackage

// File: rtl/load_align.sv
// Combinational load extraction: picks the addressed byte/half, extends it, flags misalignment.
module load_align
   import wb_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic [XLEN-1:0] read_data,
   input  logic [1:0]      load_size,
   input  logic            load_unsigned,
   input  logic [1:0]      addr_low,
   output logic [XLEN-1:0] load_data,
   output logic            misalign
);

   logic [ByteW-1:0] byte_sel;
   logic [HalfW-1:0] half_sel;

   always_comb begin
      byte_sel = read_data[7:0];
      unique case (addr_low)
         2'd0: byte_sel = read_data[7:0];
         2'd1: byte_sel = read_data[15:8];
         2'd2: byte_sel = read_data[23:16];
         2'd3: byte_sel = read_data[31:24];
         default: byte_sel = read_data[7:0];
      endcase
   end

   assign half_sel = addr_low[1] ? read_data[31:16] : read_data[15:0];

   always_comb begin
      load_data = read_data;
      misalign  = 1'b0;
      unique case (load_size_e'(load_size))
         LdByte: begin
            load_data = {{(XLEN-ByteW){~load_unsigned & byte_sel[ByteW-1]}}, byte_sel};
         end
         LdHalf: begin
            load_data = {{(XLEN-HalfW){~load_unsigned & half_sel[HalfW-1]}}, half_sel};
            misalign  = addr_low[0];
         end
         LdWord: begin
            load_data = read_data;
            misalign  = (addr_low != 2'b00);
         end
         // Reserved size: data passes through raw, the write is suppressed via misalign.
         LdRsvd: begin
            load_data = read_data;
            misalign  = 1'b1;
         end
         default: begin
            load_data = read_data;
            misalign  = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/wb_pipe_stage.sv
// MEM/WB stage register: selects and aligns the result, qualifies the write, counts retirements.
module wb_pipe_stage
   import wb_pkg::*;
#(
   parameter int unsigned XLEN    = 32,
   parameter int unsigned RADDR_W = 5,
   parameter int unsigned CNT_W   = 32
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               stall,
   input  logic               flush,
   input  logic               valid_in,
   input  logic               reg_write_in,
   input  logic [1:0]         wb_sel_in,
   input  logic [1:0]         load_size_in,
   input  logic               load_unsigned_in,
   input  logic [1:0]         addr_low_in,
   input  logic [XLEN-1:0]    read_data_in,
   input  logic [XLEN-1:0]    alu_result_in,
   input  logic [XLEN-1:0]    pc_plus4_in,
   input  logic [XLEN-1:0]    imm_in,
   input  logic [RADDR_W-1:0] reg_rd_in,
   output logic [XLEN-1:0]    wb_data_out,
   output logic [RADDR_W-1:0] reg_rd_out,
   output logic               reg_write_out,
   output logic               valid_out,
   output logic               misalign_out,
   output logic [CNT_W-1:0]   retired_cnt
);

   logic [XLEN-1:0]    load_data;
   logic               load_mis;
   logic [XLEN-1:0]    wb_data_d, wb_data_q;
   logic [RADDR_W-1:0] rd_q;
   logic               mis_d, mis_q;
   logic               we_d, we_q;
   logic               valid_q;
   logic [CNT_W-1:0]   cnt_q;

   load_align #(
      .XLEN(XLEN)
   ) u_load_align (
      .read_data    (read_data_in),
      .load_size    (load_size_in),
      .load_unsigned(load_unsigned_in),
      .addr_low     (addr_low_in),
      .load_data    (load_data),
      .misalign     (load_mis)
   );

   // Results are resolved before the register so every output comes straight from a flop.
   always_comb begin
      wb_data_d = alu_result_in;
      unique case (wb_sel_e'(wb_sel_in))
         WbAlu:   wb_data_d = alu_result_in;
         WbMem:   wb_data_d = load_data;
         WbPc4:   wb_data_d = pc_plus4_in;
         WbImm:   wb_data_d = imm_in;
         default: wb_data_d = alu_result_in;
      endcase
      mis_d = valid_in && (wb_sel_e'(wb_sel_in) == WbMem) && load_mis;
      we_d  = valid_in && reg_write_in && (reg_rd_in != '0) && !mis_d;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wb_data_q <= '0;
         rd_q      <= '0;
         mis_q     <= 1'b0;
         we_q      <= 1'b0;
         valid_q   <= 1'b0;
         cnt_q     <= '0;
      end else begin
         if (valid_q && !stall) begin
            cnt_q <= cnt_q + CNT_W'(1);
         end
         if (flush) begin
            wb_data_q <= wb_data_d;
            rd_q      <= reg_rd_in;
            mis_q     <= 1'b0;
            we_q      <= 1'b0;
            valid_q   <= 1'b0;
         end else if (!stall) begin
            wb_data_q <= wb_data_d;
            rd_q      <= reg_rd_in;
            mis_q     <= mis_d;
            we_q      <= we_d;
            valid_q   <= valid_in;
         end
      end
   end

   assign wb_data_out   = wb_data_q;
   assign reg_rd_out    = rd_q;
   assign reg_write_out = we_q;
   assign valid_out     = valid_q;
   assign misalign_out  = mis_q;
   assign retired_cnt   = cnt_q;

endmodule
